// File: rtl/riscv_v_bypass_net_if.sv
// Operand-forwarding bus between the V execute stage and the bypass network:
// live MEM/WB writes, scoreboard control, source reads and forwarded results.
interface riscv_v_bypass_net_if #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_SRCS   = 3,
   parameter int ADDR_WIDTH = 5
);
   localparam int NB = DATA_WIDTH / 8;

   logic                           flush;
   logic [NB-1:0]                  mem_wr_en;
   logic [ADDR_WIDTH-1:0]          mem_wr_addr;
   logic [DATA_WIDTH-1:0]          mem_wr_data;
   logic [NB-1:0]                  wb_wr_en;
   logic [ADDR_WIDTH-1:0]          wb_wr_addr;
   logic [DATA_WIDTH-1:0]          wb_wr_data;
   logic                           wb_pend_clr;
   logic                           pend_set;
   logic [ADDR_WIDTH-1:0]          pend_set_addr;
   logic [NUM_SRCS-1:0]            src_valid;
   logic [NUM_SRCS*ADDR_WIDTH-1:0] src_addr;
   logic [NUM_SRCS*DATA_WIDTH-1:0] src_rf_data;
   logic [NB-1:0]                  mask_rf;
   logic [NUM_SRCS*DATA_WIDTH-1:0] src_byp_data;
   logic [NB-1:0]                  mask_byp;
   logic                           stall;

   modport master (
      output flush, mem_wr_en, mem_wr_addr, mem_wr_data,
             wb_wr_en, wb_wr_addr, wb_wr_data, wb_pend_clr,
             pend_set, pend_set_addr, src_valid, src_addr, src_rf_data, mask_rf,
      input  src_byp_data, mask_byp, stall
   );

   modport slave (
      input  flush, mem_wr_en, mem_wr_addr, mem_wr_data,
             wb_wr_en, wb_wr_addr, wb_wr_data, wb_pend_clr,
             pend_set, pend_set_addr, src_valid, src_addr, src_rf_data, mask_rf,
      output src_byp_data, mask_byp, stall
   );
endinterface

// File: rtl/riscv_v_bypass_net.sv
// Vector operand bypass: per-byte forwarding from MEM, WB and a retired-write
// history, plus a pending-write scoreboard that stalls readers of late results.
module riscv_v_bypass_net #(
   parameter int DATA_WIDTH  = 128,
   parameter int NUM_SRCS    = 3,
   parameter int HIST_DEPTH  = 2,
   parameter int ADDR_WIDTH  = 5,
   parameter int MASK_RF_POS = 0
) (
   input logic                  clk,
   input logic                  rst,
   riscv_v_bypass_net_if.slave  bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int MB = DATA_WIDTH / 64;
   localparam int NREG = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] MASK_ADDR = MASK_RF_POS[ADDR_WIDTH-1:0];

   logic [NB-1:0]         hist_en   [HIST_DEPTH];
   logic [ADDR_WIDTH-1:0] hist_addr [HIST_DEPTH];
   logic [DATA_WIDTH-1:0] hist_data [HIST_DEPTH];
   logic [NREG-1:0]       pending;

   logic [NUM_SRCS*DATA_WIDTH-1:0] byp_c;
   logic [NB-1:0]                  mask_c;
   logic                           stall_c;

   // Only the byte enables and pending bits need clearing; stale addr/data
   // behind a zero enable can never be selected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < HIST_DEPTH; k++) hist_en[k] <= '0;
         pending <= '0;
      end else if (bus.flush) begin
         for (int k = 0; k < HIST_DEPTH; k++) hist_en[k] <= '0;
         pending <= '0;
      end else begin
         hist_en[0] <= bus.wb_wr_en;
         for (int k = 1; k < HIST_DEPTH; k++) hist_en[k] <= hist_en[k-1];
         if (|bus.wb_wr_en && bus.wb_pend_clr) pending[bus.wb_wr_addr] <= 1'b0;
         // Issued after the clear so a new producer on the same register wins.
         if (bus.pend_set) pending[bus.pend_set_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      hist_addr[0] <= bus.wb_wr_addr;
      hist_data[0] <= bus.wb_wr_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
         hist_addr[k] <= hist_addr[k-1];
         hist_data[k] <= hist_data[k-1];
      end
   end

   function automatic logic [7:0] resolve_byte(input logic [ADDR_WIDTH-1:0] a,
                                               input int b,
                                               input logic [7:0] fallback);
      logic [7:0] v;
      v = fallback;
      for (int k = HIST_DEPTH - 1; k >= 0; k--)
         if (hist_en[k][b] && hist_addr[k] == a) v = hist_data[k][b*8 +: 8];
      if (bus.wb_wr_en[b] && bus.wb_wr_addr == a) v = bus.wb_wr_data[b*8 +: 8];
      if (bus.mem_wr_en[b] && bus.mem_wr_addr == a) v = bus.mem_wr_data[b*8 +: 8];
      return v;
   endfunction

   always_comb begin
      byp_c   = '0;
      mask_c  = bus.mask_rf;
      stall_c = pending[MASK_ADDR];
      for (int i = 0; i < NUM_SRCS; i++) begin
         for (int b = 0; b < NB; b++)
            byp_c[i*DATA_WIDTH + b*8 +: 8] =
               resolve_byte(bus.src_addr[i*ADDR_WIDTH +: ADDR_WIDTH], b,
                            bus.src_rf_data[i*DATA_WIDTH + b*8 +: 8]);
         if (bus.src_valid[i] && pending[bus.src_addr[i*ADDR_WIDTH +: ADDR_WIDTH]])
            stall_c = 1'b1;
      end
      for (int b = 0; b < MB; b++)
         mask_c[b*8 +: 8] = resolve_byte(MASK_ADDR, b, bus.mask_rf[b*8 +: 8]);
   end

   assign bus.src_byp_data = byp_c;
   assign bus.mask_byp     = mask_c;
   assign bus.stall        = stall_c;
endmodule

// File: tb/tb_riscv_v_bypass_net.sv
// Directed test-plan scenarios followed by randomized traffic checked against
// a queue-based reference model of the forwarding and scoreboard rules.
module tb_riscv_v_bypass_net;
   localparam int DW = 128;
   localparam int NS = 3;
   localparam int HD = 2;
   localparam int AW = 5;
   localparam int NB = DW / 8;
   localparam int MB = DW / 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_v_bypass_net_if #(.DATA_WIDTH(DW), .NUM_SRCS(NS), .ADDR_WIDTH(AW)) bus ();

   riscv_v_bypass_net #(.DATA_WIDTH(DW), .NUM_SRCS(NS), .HIST_DEPTH(HD),
                        .ADDR_WIDTH(AW), .MASK_RF_POS(0))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Reference model: list of retired WB writes, youngest first, plus a set of
   // pending registers.
   typedef struct {
      logic [NB-1:0] en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t      hq[$];
   bit [31:0] pend;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hq.delete();
         pend = '0;
      end else if (bus.flush) begin
         hq.delete();
         pend = '0;
      end else begin
         hq.push_front('{bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data});
         if (hq.size() > HD) void'(hq.pop_back());
         if (|bus.wb_wr_en && bus.wb_pend_clr) pend[bus.wb_wr_addr] = 1'b0;
         if (bus.pend_set) pend[bus.pend_set_addr] = 1'b1;
      end
   end

   function automatic logic [7:0] ref_byte(input logic [AW-1:0] a, input int b,
                                           input logic [7:0] fb);
      if (bus.mem_wr_en[b] && bus.mem_wr_addr == a) return bus.mem_wr_data[b*8 +: 8];
      if (bus.wb_wr_en[b] && bus.wb_wr_addr == a) return bus.wb_wr_data[b*8 +: 8];
      foreach (hq[k])
         if (hq[k].en[b] && hq[k].addr == a) return hq[k].data[b*8 +: 8];
      return fb;
   endfunction

   task automatic check_model(input string tag);
      logic [DW-1:0] e;
      logic [NB-1:0] m;
      logic          s;
      s = pend[0];
      for (int i = 0; i < NS; i++) begin
         for (int b = 0; b < NB; b++)
            e[b*8 +: 8] = ref_byte(bus.src_addr[i*AW +: AW], b, bus.src_rf_data[i*DW + b*8 +: 8]);
         chk($sformatf("%s_src%0d", tag, i), bus.src_byp_data[i*DW +: DW], e);
         if (bus.src_valid[i] && pend[bus.src_addr[i*AW +: AW]]) s = 1'b1;
      end
      m = bus.mask_rf;
      for (int b = 0; b < MB; b++) m[b*8 +: 8] = ref_byte('0, b, bus.mask_rf[b*8 +: 8]);
      chk({tag, "_mask"}, bus.mask_byp, m);
      chk({tag, "_stall"}, bus.stall, s);
   endtask

   task automatic idle();
      bus.flush = 0;          bus.mem_wr_en = '0;   bus.mem_wr_addr = '0;
      bus.mem_wr_data = '0;   bus.wb_wr_en = '0;    bus.wb_wr_addr = '0;
      bus.wb_wr_data = '0;    bus.wb_pend_clr = 0;  bus.pend_set = 0;
      bus.pend_set_addr = '0; bus.src_valid = '0;   bus.src_addr = '0;
      bus.src_rf_data = '0;   bus.mask_rf = '0;
   endtask

   task automatic clear_state();
      @(negedge clk); idle(); bus.flush = 1;
      @(negedge clk); idle();
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0;

      // Out of reset: RF passthrough, no stall
      bus.src_rf_data = {rnd_data(), rnd_data(), rnd_data()};
      bus.mask_rf = 16'hBEEF; bus.src_valid = '1;
      #1;
      chk("rst_byp", bus.src_byp_data, bus.src_rf_data);
      chk("rst_mask", bus.mask_byp, 16'hBEEF);
      chk("rst_stall", bus.stall, 1'b0);

      // Byte merge on v3
      clear_state();
      bus.mem_wr_en = 16'h000F; bus.mem_wr_addr = 3; bus.mem_wr_data = {16{8'hAA}};
      bus.wb_wr_en = '1; bus.wb_wr_addr = 3; bus.wb_wr_data = {16{8'h55}};
      bus.src_addr[0 +: AW] = 3; bus.src_valid = 3'b001;
      #1 chk("merge", bus.src_byp_data[0 +: DW], {{12{8'h55}}, {4{8'hAA}}});

      // History aging on v7
      clear_state();
      bus.wb_wr_en = '1; bus.wb_wr_addr = 7; bus.wb_wr_data = {16{8'h11}};
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); idle();
         bus.src_addr[AW +: AW] = 7; bus.src_valid = 3'b010;
         #1 chk($sformatf("age_t%0d", c), bus.src_byp_data[DW +: DW],
                (c <= HD) ? {16{8'h11}} : 128'h0);
      end

      // Mask forwarding from v0
      clear_state();
      bus.wb_wr_en = '1; bus.wb_wr_addr = 0; bus.wb_wr_data = 128'h0FF0;
      #1 chk("mask_fwd", bus.mask_byp, 16'h0FF0);

      // Scoreboard on v9 read by src2
      clear_state();
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk); idle();
         bus.src_addr[2*AW +: AW] = 9; bus.src_valid = 3'b100;
         if (c == 0 || c == 6) begin bus.pend_set = 1; bus.pend_set_addr = 9; end
         if (c == 4 || c == 6) begin
            bus.wb_wr_en = '1; bus.wb_wr_addr = 9; bus.wb_pend_clr = 1;
            bus.wb_wr_data = {16{8'h77}};
         end
         #1 chk($sformatf("sb_t%0d", c), bus.stall, (c >= 1 && c <= 4) || c == 7);
         if (c == 4) chk("sb_clr_fwd", bus.src_byp_data[2*DW +: DW], {16{8'h77}});
      end

      // Flush: live forwarding in the flush cycle, clean state after
      clear_state();
      bus.wb_wr_en = '1; bus.wb_wr_addr = 3; bus.wb_wr_data = {16{8'h44}};
      bus.pend_set = 1; bus.pend_set_addr = 9;
      @(negedge clk); idle(); bus.flush = 1;
      bus.wb_wr_en = '1; bus.wb_wr_addr = 3; bus.wb_wr_data = {16{8'h66}};
      bus.src_addr = {5'd9, 5'd0, 5'd3}; bus.src_valid = 3'b101;
      #1 chk("fl_live", bus.src_byp_data[0 +: DW], {16{8'h66}});
      chk("fl_stall_pre", bus.stall, 1'b1);
      @(negedge clk); idle();
      bus.src_addr = {5'd9, 5'd0, 5'd3}; bus.src_valid = 3'b101;
      bus.src_rf_data = {rnd_data(), rnd_data(), rnd_data()};
      #1 chk("fl_byp", bus.src_byp_data, bus.src_rf_data);
      chk("fl_stall", bus.stall, 1'b0);

      // Asynchronous reset mid-cycle
      clear_state();
      bus.wb_wr_en = '1; bus.wb_wr_addr = 5; bus.wb_wr_data = {16{8'h33}};
      bus.pend_set = 1; bus.pend_set_addr = 0;
      @(negedge clk); idle();
      bus.src_addr = {5'd9, 5'd0, 5'd5}; bus.src_valid = 3'b001;
      bus.src_rf_data = {rnd_data(), rnd_data(), rnd_data()}; bus.mask_rf = 16'h1234;
      #1 chk("ar_pre_byp", bus.src_byp_data[0 +: DW], {16{8'h33}});
      chk("ar_pre_stall", bus.stall, 1'b1);
      #1 rst = 1;
      #1 chk("ar_byp", bus.src_byp_data, bus.src_rf_data);
      chk("ar_mask", bus.mask_byp, 16'h1234);
      chk("ar_stall", bus.stall, 1'b0);
      #1 rst = 0;

      // Randomized traffic against the reference model
      clear_state();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk); idle();
         bus.flush = ($urandom_range(0, 31) == 0);
         bus.mem_wr_en = ($urandom_range(0, 2) == 0) ? '0 : 16'($urandom);
         bus.mem_wr_addr = 5'($urandom_range(0, 4));
         bus.mem_wr_data = rnd_data();
         bus.wb_wr_en = ($urandom_range(0, 2) == 0) ? '0 : 16'($urandom);
         bus.wb_wr_addr = 5'($urandom_range(0, 4));
         bus.wb_wr_data = rnd_data();
         bus.wb_pend_clr = 1'($urandom);
         bus.pend_set = ($urandom_range(0, 5) == 0);
         bus.pend_set_addr = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
         bus.src_valid = 3'($urandom);
         for (int i = 0; i < NS; i++) bus.src_addr[i*AW +: AW] = 5'($urandom_range(0, 4));
         bus.src_rf_data = {rnd_data(), rnd_data(), rnd_data()};
         bus.mask_rf = 16'($urandom);
         #1 check_model("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
